// File: rtl/rpn_stack_engine.sv
// rtl/rpn_stack_engine.sv - reverse-Polish evaluator driving a word LIFO
//
// Purpose: accepts operand/operator tokens over a valid/ready handshake.
// Operands push onto a 2^W-entry stack. Operators pop two entries, compute,
// and push the result.
// Ports:
//   clk, reset (async active-low)
//   in_valid/in_ready/in_is_op/in_data : token stream (opcode in in_data[1:0])
//   err_clr                            : clears sticky err
//   top/top_valid/depth/err            : stack status
module rpn_stack_engine #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_is_op,
  input  logic [B-1:0] in_data,
  input  logic         err_clr,
  output logic [B-1:0] top,
  output logic         top_valid,
  output logic [W:0]   depth,
  output logic         err
);

  localparam int         NENT = 1 << W;
  localparam logic [W:0] FULL = (W+1)'(NENT);
  localparam logic [W:0] TWO  = (W+1)'(2);

  typedef enum logic [1:0] {IDLE, RD_B, RD_A, WR} state_t;

  state_t       state_q;
  logic [W:0]   depth_q;
  logic         err_q;
  logic         err_d;
  logic         in_ready_q;
  logic [1:0]   op_q;
  logic [B-1:0] a_q;
  logic [B-1:0] b_q;
  logic [B-1:0] mem [NENT];

  logic         accept;
  logic         push_ok;
  logic         ovf;
  logic         udf;
  logic         op_go;
  logic [W-1:0] idx_top;
  logic [W-1:0] idx_nxt;
  logic [B-1:0] alu_res;

  // in_ready_q is high exactly when the FSM is in IDLE
  assign accept  = in_valid & in_ready_q;
  assign push_ok = accept & ~in_is_op & (depth_q != FULL);
  assign ovf     = accept & ~in_is_op & (depth_q == FULL);
  assign udf     = accept &  in_is_op & (depth_q < TWO);
  assign op_go   = accept &  in_is_op & (depth_q >= TWO);

  // Index arithmetic only matters when depth is large enough to use it
  assign idx_top = W'(depth_q - 1'b1);
  assign idx_nxt = W'(depth_q - TWO);

  always_comb begin
    alu_res = '0;
    case (op_q)
      2'b00:   alu_res = a_q + b_q;
      2'b01:   alu_res = a_q - b_q;
      2'b10:   alu_res = a_q * b_q;
      default: alu_res = a_q ^ b_q;
    endcase
  end

  // New error wins over a coincident clear
  always_comb begin
    err_d = err_q;
    if (ovf || udf)   err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Storage is not reset; writes are gated by reset so an aborted operator
  // never lands a result.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (push_ok)
        mem[depth_q[W-1:0]] <= in_data;
      else if (state_q == WR)
        mem[idx_nxt] <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      op_q       <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (push_ok) begin
            depth_q <= depth_q + 1'b1;
          end else if (op_go) begin
            op_q       <= in_data[1:0];
            state_q    <= RD_B;
            in_ready_q <= 1'b0;
          end
        end
        RD_B: begin
          b_q     <= mem[idx_top];
          state_q <= RD_A;
        end
        RD_A: begin
          a_q     <= mem[idx_nxt];
          state_q <= WR;
        end
        default: begin
          depth_q    <= depth_q - 1'b1;
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign depth     = depth_q;
  assign err       = err_q;
  assign top       = (depth_q != '0) ? mem[idx_top] : '0;
  assign top_valid = (depth_q != '0) && (state_q == IDLE);

endmodule
